// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control FSM and the multiply/divide engine.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide engine owning HI/LO: radix-2 Booth multiply, restoring divide.
// Define MULT_DIV_UNSIGNED_EN to make op[1] select the unsigned multu/divu datapath.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one Booth / restoring step per cycle, WIDTH steps
// DONE  | final result formed; outputs load on the edge that leaves DONE
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mult_div_unit_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;

    // acc doubles as Booth accumulator and division remainder; q as multiplier and quotient
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mcand;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             fix_mult;
    logic             dz_pend;

    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             req_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             accept;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] prod_hi;

`ifdef MULT_DIV_UNSIGNED_EN
    assign req_signed = ~bus.op[1];
`else
    logic unused_op1;
    assign unused_op1 = bus.op[1];
    assign req_signed = 1'b1;
`endif

    assign accept = (state == IDLE) && bus.start;
    assign a_neg  = req_signed & bus.a[WIDTH-1];
    assign b_neg  = req_signed & bus.b[WIDTH-1];
    assign mag_a  = a_neg ? -bus.a : bus.a;
    assign mag_b  = b_neg ? -bus.b : bus.b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) begin
                if (bus.op[0] && (bus.b == '0)) state_nxt = DONE;
                else                            state_nxt = RUN;
            end
            RUN:  if (count == CW'(WIDTH - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        booth_sum = acc;
        case ({q[0], q_1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
        quo     = neg_q ? -q : q;
        rem     = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        // Booth treats the multiplier as signed; an unsigned multiplier with its MSB set needs +a<<WIDTH
        prod_hi = acc[WIDTH-1:0] + (fix_mult ? mcand[WIDTH-1:0] : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            fix_mult <= 1'b0;
            dz_pend  <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            acc      <= '0;
            q_1      <= 1'b0;
            is_div   <= bus.op[0];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            dz_pend  <= bus.op[0] && (bus.b == '0);
            if (bus.op[0]) begin
                mcand    <= {1'b0, mag_b};
                q        <= mag_a;
                fix_mult <= 1'b0;
            end else begin
                mcand    <= {a_neg, bus.a};
                q        <= bus.b;
                fix_mult <= ~req_signed & bus.b[WIDTH-1];
            end
        end else if (state == RUN) begin
            count <= count + CW'(1);
            if (is_div) begin
                if (shifted >= mcand) begin
                    acc <= shifted - mcand;
                    q   <= {q[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= shifted;
                    q   <= {q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {acc, q, q_1} <= {booth_sum[WIDTH], booth_sum, q};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
        end else begin
            done_r     <= (state == DONE);
            div_zero_r <= (state == DONE) && dz_pend;
            if ((state == DONE) && !dz_pend) begin
                hi_r <= is_div ? rem : prod_hi;
                lo_r <= is_div ? quo : q;
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
endmodule
